// File: rtl/argon_pkg.sv
// Shared constants and types for the Argon memory controller and its lane helpers.
package argon_pkg;
  localparam logic [2:0] RDMASK_NONE = 3'd0;
  localparam logic [2:0] RDMASK_B    = 3'd1;
  localparam logic [2:0] RDMASK_BU   = 3'd2;
  localparam logic [2:0] RDMASK_H    = 3'd3;
  localparam logic [2:0] RDMASK_HU   = 3'd4;
  localparam logic [2:0] RDMASK_W    = 3'd5;

  localparam logic [1:0] WRMASK_NONE = 2'd0;
  localparam logic [1:0] WRMASK_B    = 2'd1;
  localparam logic [1:0] WRMASK_H    = 2'd2;
  localparam logic [1:0] WRMASK_W    = 2'd3;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;

  typedef enum logic [2:0] {IDLE, CHECK, ACCESS, WAIT, RESP, DONE, FAULT} mem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [2:0]  rd_mask;
    logic [1:0]  wr_mask;
  } mem_req_t;
endpackage

// File: rtl/argon_mem_ctrl_if.sv
// Core-side load/store handshake between the Argon core FSM and the memory controller.
interface argon_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [2:0]  rd_mask;
  logic [1:0]  wr_mask;
  logic [31:0] rd_data;
  logic        done;
  logic        fault;

  modport master (output req_valid, addr, wr_data, rd_mask, wr_mask,
                  input  req_ready, rd_data, done, fault);
  modport slave  (input  req_valid, addr, wr_data, rd_mask, wr_mask,
                  output req_ready, rd_data, done, fault);
endinterface

// File: rtl/argon_lane_align.sv
// Combinational byte-lane steering: store replication + byte enables, load extract + extend.
module argon_lane_align
  import argon_pkg::*;
#(
  parameter int NUM_LANES = argon_pkg::NUM_LANES,
  parameter int VEC_W     = argon_pkg::VEC_W,
  localparam int DW       = NUM_LANES * VEC_W,
  localparam int AW       = $clog2(NUM_LANES)
) (
  input  logic [AW-1:0]        addr_lo,
  input  logic [2:0]           rd_mask,
  input  logic [1:0]           wr_mask,
  input  logic [DW-1:0]        st_data,
  input  logic [DW-1:0]        ld_word,
  output logic [NUM_LANES-1:0] be,
  output logic [DW-1:0]        st_rep,
  output logic [DW-1:0]        ld_data
);
  logic [VEC_W-1:0]   ld_byte;
  logic [2*VEC_W-1:0] ld_half;

  // Reads (wr_mask NONE) enable every lane; the whole word comes back.
  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    localparam logic HI = logic'((n / 2) % 2);
    assign st_rep[n*VEC_W +: VEC_W] =
      (wr_mask == WRMASK_W) ? st_data[n*VEC_W +: VEC_W] :
      (wr_mask == WRMASK_H) ? st_data[(n%2)*VEC_W +: VEC_W] :
                              st_data[VEC_W-1:0];
    assign be[n] =
      (wr_mask == WRMASK_B) ? (addr_lo == AW'(n)) :
      (wr_mask == WRMASK_H) ? (addr_lo[AW-1] == HI) : 1'b1;
  end

  assign ld_byte = ld_word[addr_lo*VEC_W +: VEC_W];
  assign ld_half = addr_lo[AW-1] ? ld_word[DW-1 -: 2*VEC_W] : ld_word[2*VEC_W-1:0];

  always_comb begin
    ld_data = ld_word;
    case (rd_mask)
      RDMASK_B:  ld_data = {{(DW-VEC_W){ld_byte[VEC_W-1]}}, ld_byte};
      RDMASK_BU: ld_data = {{(DW-VEC_W){1'b0}}, ld_byte};
      RDMASK_H:  ld_data = {{(DW-2*VEC_W){ld_half[2*VEC_W-1]}}, ld_half};
      RDMASK_HU: ld_data = {{(DW-2*VEC_W){1'b0}}, ld_half};
      default:   ld_data = ld_word;
    endcase
  end
endmodule

// File: rtl/argon_mem_ctrl.sv
// Argon load/store controller: validates one request at a time and drives a single-port SRAM.
module argon_mem_ctrl
  import argon_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic              sys_clk,
  input  logic              i_reset,
  argon_mem_if.slave        core,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [3:0]        o_ram_be,
  output logic [31:0]       o_ram_wdata,
  input  logic [31:0]       i_ram_rdata
);
  mem_state_t  state;
  mem_req_t    req;
  logic [3:0]  wait_cnt;
  logic [31:0] rd_data_q;
  logic        done_q, fault_q;
  logic        bad;
  logic [3:0]  al_be;
  logic [31:0] al_st, al_ld;
  logic        is_rd, is_wr;

  assign core.req_ready = (state == IDLE);
  assign core.rd_data   = rd_data_q;
  assign core.done      = done_q;
  assign core.fault     = fault_q;

  assign is_rd = (req.rd_mask != RDMASK_NONE);
  assign is_wr = (req.wr_mask != WRMASK_NONE);

  argon_lane_align u_align (
    .addr_lo (req.addr[1:0]),
    .rd_mask (req.rd_mask),
    .wr_mask (req.wr_mask),
    .st_data (req.wr_data),
    .ld_word (i_ram_rdata),
    .be      (al_be),
    .st_rep  (al_st),
    .ld_data (al_ld)
  );

  always_comb begin
    bad = 1'b0;
    if (req.rd_mask > RDMASK_W) bad = 1'b1;
    if (is_rd && is_wr) bad = 1'b1;
    if ((req.rd_mask == RDMASK_H || req.rd_mask == RDMASK_HU || req.wr_mask == WRMASK_H)
        && req.addr[0]) bad = 1'b1;
    if ((req.rd_mask == RDMASK_W || req.wr_mask == WRMASK_W) && (req.addr[1:0] != 2'b00))
      bad = 1'b1;
    // Anything above the SRAM's byte range is out of bounds.
    if ((req.addr >> (ADDR_W + 2)) != 32'd0) bad = 1'b1;
  end

  // Completion goes straight back to IDLE so the done/fault cycle can accept a new request.
  always_ff @(posedge sys_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      req         <= '0;
      wait_cnt    <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_be    <= '0;
      o_ram_wdata <= '0;
    end else begin
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_be    <= '0;
      o_ram_wdata <= '0;
      case (state)
        IDLE: if (core.req_valid) begin
          req   <= '{addr: core.addr, wr_data: core.wr_data,
                     rd_mask: core.rd_mask, wr_mask: core.wr_mask};
          state <= CHECK;
        end
        CHECK: begin
          if (bad) begin
            fault_q <= 1'b1;
            state   <= IDLE;
          end else if (!is_rd && !is_wr) begin
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            o_ram_en    <= 1'b1;
            o_ram_we    <= is_wr;
            o_ram_be    <= al_be;
            o_ram_wdata <= is_wr ? al_st : 32'd0;
            o_ram_addr  <= req.addr[ADDR_W+1:2];
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (WAIT_STATES > 0) begin
            wait_cnt <= 4'(WAIT_STATES - 1);
            state    <= WAIT;
          end else begin
            state <= RESP;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          if (is_rd) rd_data_q <= al_ld;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_argon_mem_ctrl.sv
// Directed bench: one zero-wait and one 3-wait controller sharing a byte-enabled SRAM model.
module tb_argon_mem_ctrl;
  import argon_pkg::*;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  argon_mem_if m0();
  argon_mem_if m1();

  logic          en0, we0, en1, we1;
  logic [AW-1:0] ad0, ad1;
  logic [3:0]    be0, be1;
  logic [31:0]   wd0, wd1, rd0, rd1;

  argon_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(0)) dut0 (
    .sys_clk(clk), .i_reset(rst), .core(m0),
    .o_ram_en(en0), .o_ram_we(we0), .o_ram_addr(ad0), .o_ram_be(be0),
    .o_ram_wdata(wd0), .i_ram_rdata(rd0));

  argon_mem_ctrl #(.ADDR_W(AW), .WAIT_STATES(3)) dut1 (
    .sys_clk(clk), .i_reset(rst), .core(m1),
    .o_ram_en(en1), .o_ram_we(we1), .o_ram_addr(ad1), .o_ram_be(be1),
    .o_ram_wdata(wd1), .i_ram_rdata(rd1));

  // SRAM model: read word appears WAIT+1 cycles after enable, garbage otherwise.
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          poke_v = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [31:0]   poke_d = '0;
  logic [31:0]   q0, q1;
  logic [3:0]    dl0, dl1;
  logic          p0 = 1'b0, p1 = 1'b0;

  always @(posedge clk) begin
    if (poke_v) mem[poke_a] <= poke_d;
    if (en0) begin
      if (we0) for (int b = 0; b < 4; b++) if (be0[b]) mem[ad0][b*8 +: 8] <= wd0[b*8 +: 8];
      q0 <= mem[ad0]; dl0 <= 4'd0; p0 <= 1'b1;
    end else if (p0) begin
      if (dl0 == 4'd0) p0 <= 1'b0; else dl0 <= dl0 - 4'd1;
    end
    if (en1) begin
      if (we1) for (int b = 0; b < 4; b++) if (be1[b]) mem[ad1][b*8 +: 8] <= wd1[b*8 +: 8];
      q1 <= mem[ad1]; dl1 <= 4'd3; p1 <= 1'b1;
    end else if (p1) begin
      if (dl1 == 4'd0) p1 <= 1'b0; else dl1 <= dl1 - 4'd1;
    end
  end
  assign rd0 = (p0 && dl0 == 4'd0) ? q0 : 32'hA5A5A5A5;
  assign rd1 = (p1 && dl1 == 4'd0) ? q1 : 32'hA5A5A5A5;

  task automatic poke(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk); poke_a = a; poke_d = d; poke_v = 1'b1;
    @(negedge clk); poke_v = 1'b0;
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] rm, input logic [1:0] wm);
    if (d == 0) begin m0.req_valid = v; m0.addr = a; m0.wr_data = wd; m0.rd_mask = rm; m0.wr_mask = wm; end
    else        begin m1.req_valid = v; m1.addr = a; m1.wr_data = wd; m1.rd_mask = rm; m1.wr_mask = wm; end
  endtask

  // Issues one request and watches it to completion; k counts cycles after the accept cycle.
  task automatic run_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] rm, input logic [1:0] wm,
                         output int lat, output logic flt, output int en_n, output int en_k,
                         output logic [AW-1:0] ea, output logic [3:0] ebe, output logic [31:0] ewd,
                         output logic ewe, output logic both, output logic [31:0] rdo);
    @(negedge clk);
    drive(d, 1'b1, a, wd, rm, wm);
    @(posedge clk); #1;
    drive(d, 1'b0, a, wd, rm, wm);
    lat = -1; flt = 1'b0; en_n = 0; en_k = -1; both = 1'b0;
    ea = '0; ebe = '0; ewd = '0; ewe = 1'b0; rdo = '0;
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if ((d == 0) ? en0 : en1) begin
        en_n++;
        if (en_k < 0) begin
          en_k = k;
          ea  = (d == 0) ? ad0 : ad1;  ebe = (d == 0) ? be0 : be1;
          ewd = (d == 0) ? wd0 : wd1;  ewe = (d == 0) ? we0 : we1;
        end
      end
      if (d == 0) begin
        if (m0.done && m0.fault) both = 1'b1;
        if (m0.done || m0.fault) begin lat = k; flt = m0.fault; rdo = m0.rd_data; end
      end else begin
        if (m1.done && m1.fault) both = 1'b1;
        if (m1.done || m1.fault) begin lat = k; flt = m1.fault; rdo = m1.rd_data; end
      end
    end
  endtask

  int lat, en_n, en_k;
  logic flt, ewe, both;
  logic [AW-1:0] ea;
  logic [3:0] ebe;
  logic [31:0] ewd, rdo;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m0.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", m0.req_ready); end
    checks++; if ({m0.done, m0.fault, en0, we0} !== 4'b0) begin failures++; $display("FAIL rst_pulses got=%b exp=0000", {m0.done, m0.fault, en0, we0}); end
    checks++; if (m0.rd_data !== 32'h0) begin failures++; $display("FAIL rst_rd_data got=%h exp=0", m0.rd_data); end
    checks++; if ({ad0, be0, wd0} !== '0) begin failures++; $display("FAIL rst_ram_bus got=%h/%h/%h exp=0", ad0, be0, wd0); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++; if (m1.req_ready !== 1'b1 || en1 !== 1'b0) begin failures++; $display("FAIL rst_idle1 got=%b%b exp=10", m1.req_ready, en1); end
  endtask

  task automatic test_load_word();
    run_req(0, 32'h100, 32'h0, RDMASK_W, WRMASK_NONE, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
    checks++; if (en_k !== 2 || en_n !== 1) begin failures++; $display("FAIL lw_en got=k%0d n%0d exp=k2 n1", en_k, en_n); end
    checks++; if (ea !== 14'h40 || ebe !== 4'hF || ewe !== 1'b0) begin failures++; $display("FAIL lw_bus got=%h/%h/%b exp=40/f/0", ea, ebe, ewe); end
    checks++; if (lat !== 4 || flt !== 1'b0) begin failures++; $display("FAIL lw_lat got=%0d/%b exp=4/0", lat, flt); end
    checks++; if (rdo !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", rdo); end
  endtask

  task automatic test_load_extend();
    logic [31:0] va [5];
    logic [2:0]  vm [5];
    logic [31:0] ve [5];
    poke(14'h40, 32'h80FF7F01);
    va = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    vm = '{RDMASK_B, RDMASK_BU, RDMASK_H, RDMASK_HU, RDMASK_B};
    ve = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01, 32'h0000007F};
    for (int i = 0; i < 5; i++) begin
      run_req(0, va[i], 32'h0, vm[i], WRMASK_NONE, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
      checks++; if (rdo !== ve[i] || lat !== 4) begin failures++; $display("FAIL ld_ext%0d got=%h/%0d exp=%h/4", i, rdo, lat, ve[i]); end
    end
  endtask

  task automatic test_store();
    run_req(0, 32'h101, 32'h000000AB, RDMASK_NONE, WRMASK_B, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
    checks++; if (ebe !== 4'b0010 || ewd !== 32'hABABABAB || ewe !== 1'b1 || en_n !== 1) begin failures++; $display("FAIL sb_bus got=%b/%h/%b/%0d exp=0010/abababab/1/1", ebe, ewd, ewe, en_n); end
    checks++; if (lat !== 4 || rdo !== 32'h0000007F) begin failures++; $display("FAIL sb_done got=%0d/%h exp=4/0000007f", lat, rdo); end
    checks++; if (mem[14'h40] !== 32'h80FFAB01) begin failures++; $display("FAIL sb_mem got=%h exp=80ffab01", mem[14'h40]); end
    run_req(0, 32'h102, 32'h00001234, RDMASK_NONE, WRMASK_H, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
    checks++; if (ebe !== 4'b1100 || ewd !== 32'h12341234) begin failures++; $display("FAIL sh_bus got=%b/%h exp=1100/12341234", ebe, ewd); end
    run_req(0, 32'h104, 32'hCAFEF00D, RDMASK_NONE, WRMASK_W, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
    checks++; if (ea !== 14'h41 || ebe !== 4'hF || ewd !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_bus got=%h/%h/%h exp=41/f/cafef00d", ea, ebe, ewd); end
    run_req(0, 32'h100, 32'h0, RDMASK_W, WRMASK_NONE, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
    checks++; if (rdo !== 32'h1234AB01) begin failures++; $display("FAIL st_readback got=%h exp=1234ab01", rdo); end
  endtask

  task automatic test_fault();
    logic [31:0] va [6];
    logic [2:0]  vm [6];
    logic [1:0]  vw [6];
    va = '{32'h102, 32'h101, 32'h0001_0000, 32'h100, 32'h100, 32'h101};
    vm = '{RDMASK_W, RDMASK_NONE, RDMASK_W, 3'd6, RDMASK_B, RDMASK_H};
    vw = '{WRMASK_NONE, WRMASK_H, WRMASK_NONE, WRMASK_NONE, WRMASK_B, WRMASK_NONE};
    for (int i = 0; i < 6; i++) begin
      run_req(0, va[i], 32'h0, vm[i], vw[i], lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
      checks++; if (lat !== 2 || flt !== 1'b1 || en_n !== 0 || both !== 1'b0) begin failures++; $display("FAIL fault%0d got=lat%0d f%b en%0d both%b exp=lat2 f1 en0 both0", i, lat, flt, en_n, both); end
    end
    run_req(0, 32'h100, 32'h0, RDMASK_NONE, WRMASK_NONE, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
    checks++; if (lat !== 2 || flt !== 1'b0 || en_n !== 0) begin failures++; $display("FAIL none_none got=lat%0d f%b en%0d exp=lat2 f0 en0", lat, flt, en_n); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1, 1'b1, 32'h100, 32'h0, RDMASK_W, WRMASK_NONE);
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h104, 32'h0, RDMASK_W, WRMASK_NONE);
    for (int k = 1; k <= 7; k++) @(negedge clk);
    checks++; if (m1.done !== 1'b1 || m1.req_ready !== 1'b1) begin failures++; $display("FAIL ws_done_k7 got=%b%b exp=11", m1.done, m1.req_ready); end
    checks++; if (m1.rd_data !== 32'h1234AB01) begin failures++; $display("FAIL ws_data got=%h exp=1234ab01", m1.rd_data); end
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h104, 32'h0, RDMASK_W, WRMASK_NONE);
    @(negedge clk);
    checks++; if (m1.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%b exp=0", m1.req_ready); end
    lat = -1;
    for (int k = 9; k <= 30 && lat < 0; k++) begin
      @(negedge clk);
      if (m1.done || m1.fault) lat = k;
    end
    checks++; if (lat !== 14 || m1.rd_data !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_second got=%0d/%h exp=14/cafef00d", lat, m1.rd_data); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    drive(1, 1'b1, 32'h100, 32'h0, RDMASK_W, WRMASK_NONE);
    @(posedge clk); #1;
    drive(1, 1'b0, 32'h100, 32'h0, RDMASK_W, WRMASK_NONE);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (en1 !== 1'b0 || m1.req_ready !== 1'b1 || m1.rd_data !== 32'h0) begin failures++; $display("FAIL midrst got=en%b rdy%b rd%h exp=en0 rdy1 rd0", en1, m1.req_ready, m1.rd_data); end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (m1.done || m1.fault) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_pulse got=%b exp=0", seen); end
    run_req(1, 32'h104, 32'h0, RDMASK_W, WRMASK_NONE, lat, flt, en_n, en_k, ea, ebe, ewd, ewe, both, rdo);
    checks++; if (lat !== 7 || rdo !== 32'hCAFEF00D) begin failures++; $display("FAIL midrst_next got=%0d/%h exp=7/cafef00d", lat, rdo); end
  endtask

  initial begin
    drive(0, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE);
    drive(1, 1'b0, 32'h0, 32'h0, RDMASK_NONE, WRMASK_NONE);
    test_reset();
    poke(14'h40, 32'hDEADBEEF);
    test_load_word();
    test_load_extend();
    test_store();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
